bram_responder: RTL
===================

// Module: bram_responder
// PURPOSE
//  Synthesizable responder for the accelerator memory interface (R_req/addr/R_data/W_req/W_data).
//  One instance backs each of the conv engine's M0/M1/M2 ports: M0 holds the input image, M1/M2 hold layer results.
//  A second host-side port preloads the memory and dumps results with a valid/ready handshake.
//  It replaces the behavioural memory model in hardware builds.
// PARAMETERS
//  DEPTH   4096  number of 32-bit words; power of two
//  DATA_W  32    word width; must be 32 (4 byte lanes)
//  ADDR_W  32    width of addr / h_addr; word-indexed, low $clog2(DEPTH) bits decode
// PORTS
//  clk        in   1       clock
//  rst        in   1       asynchronous, active-low reset
//  R_req      in   1       accelerator read request
//  addr       in   ADDR_W  accelerator word address (shared by read and write)
//  R_data     out  32      read data, valid the cycle after R_req
//  W_req      in   4       byte write enables; bit3 -> [31:24] ... bit0 -> [7:0]
//  W_data     in   32      write data
//  h_valid    in   1       host request valid
//  h_ready    out  1       host request accepted when h_valid & h_ready
//  h_we       in   1       1 = write full word, 0 = read
//  h_addr     in   ADDR_W  host word address
//  h_wdata    in   32      host write data
//  h_rvalid   out  1       one-cycle pulse; h_rdata valid
//  h_rdata    out  32      host read data
//  init_done  out  1       memory usable
//  addr_err   out  1       sticky: an out-of-range access occurred
// BEHAVIOUR
//  Reset: R_data=0, h_rdata=0, h_rvalid=0, h_ready=0, addr_err=0; memory contents are not reset.
//  Accelerator read: R_req at edge N -> R_data = mem[addr] after edge N+1. R_data holds until the next R_req.
//  Accelerator write: W_req!=0 at edge N updates only the enabled lanes at edge N.
//  Same-cycle R_req and W_req to the same address: read-first (R_data returns the old word).
//  Priority: the accelerator has no stall, so it always wins. h_ready = init_done & ~R_req & ~|W_req, combinational.
//  Host read accepted at edge N -> h_rvalid=1 and h_rdata=mem[h_addr] for the cycle after edge N+1. Back-to-back reads are allowed.
//  Host write accepted at edge N writes all 4 lanes at edge N. No h_rvalid is generated for writes.
//  Out of range (address >= DEPTH) on either port:
//   - reads return 32'h0, writes are dropped
//   - addr_err is set and cleared only by reset
//  FSM: INIT -> IDLE. IDLE is permanent until reset. Reset asserted mid-operation returns to INIT and drops any pending h_rvalid.
//  While init_done=0: accelerator requests are ignored (R_data stays 0), h_ready=0.
// CONFIGURATION
//  BRAM_RESP_INIT_EN defined:
//   - INIT walks a word counter 0..DEPTH-1 and writes 0 to each word, one word per cycle.
//   - init_done rises the cycle after the last word is written, i.e. DEPTH+1 cycles after reset release.
//  BRAM_RESP_INIT_EN undefined:
//   - INIT lasts one cycle; init_done=1 from the first edge after reset release.
//   - Contents are undefined until written.
// STRUCTURE
//  Package bram_resp_pkg:
//   - LANES=4 and byte-lane slice constants
//   - state enum {ST_INIT, ST_IDLE}
//   - function in_range(addr, DEPTH)
//  Sub-module bram_core: single-port, read-first, byte-enabled storage array (1-cycle read).
//  Top level contains the port mux, init FSM/counter, host handshake and error flag.
// TESTING
//  1. Reset release, INIT_EN off -> init_done=1 after 1 edge; with INIT_EN, DEPTH=16 -> init_done=1 after 17 edges and all 16 words read 0.
//  2. Host write 0x0000_00AB at 5, then host read 5 -> h_rvalid pulses once with h_rdata=0x0000_00AB.
//  3. mem[3]=0x11223344; W_req=4'b0101, W_data=0xAABBCCDD at addr 3 -> mem[3]=0x11BB33DD.
//  4. R_req+W_req=4'hF same cycle at addr 7 (old 0x1, new 0x2) -> R_data=0x1, next read 0x2.
//  5. h_valid held while R_req pulses -> h_ready=0 that cycle; host accepted the next cycle and the accelerator read is unaffected.
//  6. Accelerator read at addr DEPTH -> R_data=0, addr_err=1; stays 1 until rst=0.

Source files
------------

// File: rtl/bram_resp_pkg.sv
// rtl/bram_resp_pkg.sv - shared constants, state type and range check for bram_responder
package bram_resp_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int WORD_W = LANES * LANE_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    // Word address decodes to a real location only below the array depth.
    function automatic logic in_range(input logic [63:0] a, input int unsigned depth);
        return a < 64'(depth);
    endfunction

endpackage

// File: rtl/bram_responder_if.sv
// rtl/bram_responder_if.sv - accelerator and host bus bundle for bram_responder
//  Accelerator side: R_req, addr, W_req, W_data in; R_data out.
//  Host side: h_valid, h_we, h_addr, h_wdata in; h_ready, h_rvalid, h_rdata out.
//  master = requester (conv engine / host), slave = bram_responder.
interface bram_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              R_req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] R_data;
    logic [3:0]        W_req;
    logic [DATA_W-1:0] W_data;

    logic              h_valid;
    logic              h_ready;
    logic              h_we;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic              h_rvalid;
    logic [DATA_W-1:0] h_rdata;

    modport master (
        output R_req, addr, W_req, W_data,
        output h_valid, h_we, h_addr, h_wdata,
        input  R_data, h_ready, h_rvalid, h_rdata
    );

    modport slave (
        input  R_req, addr, W_req, W_data,
        input  h_valid, h_we, h_addr, h_wdata,
        output R_data, h_ready, h_rvalid, h_rdata
    );
endinterface

// File: rtl/bram_core.sv
// rtl/bram_core.sv - single-port read-first byte-enabled storage array, 1-cycle read
//  Ports: clk; en (access), we (per-lane write enable), idx (word index),
//  wdata (write word); rdata (registered old word at idx when en).
module bram_core
    import bram_resp_pkg::*;
#(
    parameter int DEPTH = 4096,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic [LANES-1:0]  we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Read samples the array before this edge's write lands (read-first).
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[idx];
            for (int i = 0; i < LANES; i++) begin
                if (we[i]) begin
                    mem[idx][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

endmodule

// File: rtl/bram_responder.sv
// rtl/bram_responder.sv - accelerator/host memory responder with init FSM and error flag
//  Ports: clk; rst (async, active-low); bus (bram_responder_if.slave: accelerator
//  R_req/addr/W_req/W_data/R_data and host h_* handshake); init_done; addr_err (sticky).
//  Optional: BRAM_RESP_INIT_EN zero-fills the array after reset, one word per cycle.
module bram_responder
    import bram_resp_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    bram_responder_if.slave   bus,
    output logic              init_done,
    output logic              addr_err
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t state_q, state_d;

    logic [ADDR_W-1:0] acc_addr, host_addr;
    logic              acc_rd, acc_active, acc_ok;
    logic              host_fire, host_ok, host_rd;

    logic              core_en;
    logic [LANES-1:0]  core_we;
    logic [IDX_W-1:0]  core_idx;
    logic [DATA_W-1:0] core_wdata, core_rdata;

    // First pipeline stage: what the core is reading this cycle and whether it is masked.
    logic acc_rd_q, acc_oor_q, host_rd_q, host_oor_q;

`ifdef BRAM_RESP_INIT_EN
    localparam logic [IDX_W:0] CNT_END = (IDX_W+1)'(DEPTH);
    logic [IDX_W:0] init_cnt;
`endif

    assign acc_addr  = bus.addr;
    assign host_addr = bus.h_addr;
    assign init_done = (state_q == ST_IDLE);

    assign acc_ok     = in_range(64'(acc_addr), DEPTH);
    assign acc_rd     = init_done & bus.R_req;
    assign acc_active = init_done & (bus.R_req | (|bus.W_req));

    // The accelerator cannot stall, so any accelerator activity blocks the host.
    assign bus.h_ready = init_done & ~bus.R_req & ~(|bus.W_req);
    assign host_ok     = in_range(64'(host_addr), DEPTH);
    assign host_fire   = bus.h_valid & bus.h_ready;
    assign host_rd     = host_fire & ~bus.h_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_INIT;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
`ifdef BRAM_RESP_INIT_EN
                if (init_cnt == CNT_END) state_d = ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_IDLE: state_d = ST_IDLE;
            default: state_d = ST_INIT;
        endcase
    end

`ifdef BRAM_RESP_INIT_EN
    // Counts one past the last word so IDLE is entered the cycle after the final write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_cnt <= '0;
        end else if (state_q == ST_INIT && init_cnt != CNT_END) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        core_en    = 1'b0;
        core_we    = '0;
        core_idx   = '0;
        core_wdata = '0;
        if (state_q == ST_INIT) begin
`ifdef BRAM_RESP_INIT_EN
            if (init_cnt != CNT_END) begin
                core_en  = 1'b1;
                core_we  = '1;
                core_idx = init_cnt[IDX_W-1:0];
            end
`endif
        end else if (acc_active) begin
            core_en    = 1'b1;
            core_we    = acc_ok ? bus.W_req : '0;
            core_idx   = acc_addr[IDX_W-1:0];
            core_wdata = bus.W_data;
        end else if (host_fire) begin
            core_en    = 1'b1;
            core_we    = (bus.h_we & host_ok) ? '1 : '0;
            core_idx   = host_addr[IDX_W-1:0];
            core_wdata = bus.h_wdata;
        end
    end

    bram_core #(.DEPTH(DEPTH)) u_core (
        .clk   (clk),
        .en    (core_en),
        .we    (core_we),
        .idx   (core_idx),
        .wdata (core_wdata),
        .rdata (core_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_rd_q     <= 1'b0;
            acc_oor_q    <= 1'b0;
            host_rd_q    <= 1'b0;
            host_oor_q   <= 1'b0;
            bus.R_data   <= '0;
            bus.h_rvalid <= 1'b0;
            bus.h_rdata  <= '0;
            addr_err     <= 1'b0;
        end else begin
            acc_rd_q   <= acc_rd;
            acc_oor_q  <= ~acc_ok;
            host_rd_q  <= host_rd;
            host_oor_q <= ~host_ok;

            // R_data and h_rdata hold their last value between reads.
            if (acc_rd_q) bus.R_data <= acc_oor_q ? '0 : core_rdata;
            bus.h_rvalid <= host_rd_q;
            if (host_rd_q) bus.h_rdata <= host_oor_q ? '0 : core_rdata;

            if ((acc_active & ~acc_ok) | (host_fire & ~host_ok)) addr_err <= 1'b1;
        end
    end

endmodule
